// File: rtl/cache_controller.sv
// cache_controller
//   Write-back / write-allocate control FSM placed directly upstream of a
//   4-way set-associative cache_memory. Accepts one CPU word request at a
//   time, splits the word address into {tag, index, offset}, drives the
//   cache strobes, and sequences dirty-victim write-back plus line refill
//   against main memory over a req/ack handshake. Keeps saturating
//   hit / miss / write-back statistics.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cpu_req_valid/type/addr/wdata  CPU request (type 0=read, 1=write)
//   cpu_ready                  high only in IDLE
//   cpu_resp_valid, cpu_rdata  one-cycle completion pulse, read data
//   tag, index, blk_offset, req_type, data_in   latched request to cache
//   read_en_cache, write_en_cache, read_en_mem, write_en_mem   cache strobes
//   hit, dirty_bit, data_out   status / registered read word from cache
//   mem_req, mem_we, mem_ack   memory handshake (mem_we 1=write-back)
//   hit_cnt, miss_cnt, wb_cnt  saturating statistics
//   state_dbg                  current FSM state (debug visibility)
//
// Handshakes
//   CPU: a request transfers on the rising edge where cpu_req_valid and
//   cpu_ready are both high; inputs are sampled only then. cpu_resp_valid
//   is a single-cycle pulse with no back-pressure.
//   Memory: mem_req (with mem_we) stays high until the cycle mem_ack is
//   seen; that cycle completes the transfer. mem_ack is ignored whenever
//   mem_req is low.

module cache_controller #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 16,
  parameter int ADDR_WIDTH      = 31,
  parameter int CNT_WIDTH       = 16,
  localparam int OFFSET_WIDTH   = $clog2(WORDS_PER_BLOCK),
  localparam int INDEX_WIDTH    = $clog2(NUM_SETS),
  localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_type,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_resp_valid,
  output logic [WORD_SIZE-1:0]    cpu_rdata,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic [OFFSET_WIDTH-1:0] blk_offset,
  output logic                    req_type,
  output logic [WORD_SIZE-1:0]    data_in,
  output logic                    read_en_cache,
  output logic                    write_en_cache,
  output logic                    read_en_mem,
  output logic                    write_en_mem,
  input  logic                    hit,
  input  logic                    dirty_bit,
  input  logic [WORD_SIZE-1:0]    data_out,
  output logic                    mem_req,
  output logic                    mem_we,
  input  logic                    mem_ack,
  output logic [CNT_WIDTH-1:0]    hit_cnt,
  output logic [CNT_WIDTH-1:0]    miss_cnt,
  output logic [CNT_WIDTH-1:0]    wb_cnt,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    WRITE_BACK = 3'd2,
    ALLOCATE   = 3'd3,
    RESPOND    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    refilled_q, refilled_d;
  logic                    wb_first_q, wb_first_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic                    req_type_q, req_type_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]    wb_cnt_q, wb_cnt_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      refilled_q <= 1'b0;
      wb_first_q <= 1'b0;
      tag_q      <= '0;
      index_q    <= '0;
      offset_q   <= '0;
      req_type_q <= 1'b0;
      wdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      refilled_q <= refilled_d;
      wb_first_q <= wb_first_d;
      tag_q      <= tag_d;
      index_q    <= index_d;
      offset_q   <= offset_d;
      req_type_q <= req_type_d;
      wdata_q    <= wdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    refilled_d     = refilled_q;
    wb_first_d     = 1'b0;
    tag_d          = tag_q;
    index_d        = index_q;
    offset_d       = offset_q;
    req_type_d     = req_type_q;
    wdata_d        = wdata_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    wb_cnt_d       = wb_cnt_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_rdata      = '0;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    read_en_mem    = 1'b0;
    write_en_mem   = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) begin
          tag_d      = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          index_d    = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
          offset_d   = cpu_addr[OFFSET_WIDTH-1:0];
          req_type_d = cpu_req_type;
          wdata_d    = cpu_wdata;
          refilled_d = 1'b0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        // After a refill the lookup is re-run; the request was already
        // counted as a miss, so neither counter moves on the retry.
        if (hit) begin
          if (req_type_q) write_en_cache = 1'b1;
          else            read_en_cache  = 1'b1;
          if (!refilled_q) hit_cnt_d = sat_inc(hit_cnt_q);
          state_d = RESPOND;
        end else begin
          if (!refilled_q) miss_cnt_d = sat_inc(miss_cnt_q);
          if (dirty_bit) begin
            wb_first_d = 1'b1;
            state_d    = WRITE_BACK;
          end else begin
            state_d    = ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        // The cache captures the victim block and clears its dirty bit on
        // this all-strobes pattern; it must be seen exactly once.
        if (wb_first_q) begin
          read_en_cache  = 1'b1;
          write_en_cache = 1'b1;
          read_en_mem    = 1'b1;
          write_en_mem   = 1'b1;
        end
        if (mem_ack) begin
          wb_cnt_d = sat_inc(wb_cnt_q);
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          read_en_mem    = 1'b1;
          write_en_cache = 1'b1;
          refilled_d     = 1'b1;
          state_d        = COMPARE;
        end
      end
      RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_rdata      = req_type_q ? '0 : data_out;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tag        = tag_q;
  assign index      = index_q;
  assign blk_offset = offset_q;
  assign req_type   = req_type_q;
  assign data_in    = wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign wb_cnt     = wb_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller. The bench plays both the cache (hit /
// dirty decisions per transaction, registered read word that encodes the
// address) and main memory (ack after a chosen wait). Expected latency,
// handshake activity and counter values come from a transaction-level
// model of the rules. Counters are built narrow so saturation is reached.

module tb_cache_controller;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid, cpu_req_type;
  logic [30:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic [24:0] tag;
  logic [3:0]  index;
  logic [1:0]  blk_offset;
  logic        req_type;
  logic [31:0] data_in;
  logic        read_en_cache, write_en_cache, read_en_mem, write_en_mem;
  logic        hit, dirty_bit;
  logic [31:0] data_out = '0;
  logic        mem_req, mem_we, mem_ack;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int hit_m = 0, miss_m = 0, wb_m = 0;

  cache_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .tag(tag), .index(index), .blk_offset(blk_offset),
    .req_type(req_type), .data_in(data_in),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
    .hit(hit), .dirty_bit(dirty_bit), .data_out(data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Word the fake cache returns for a given word address.
  function automatic logic [31:0] word_of(input logic [30:0] a);
    return {a, 1'b0} ^ 32'hA5A5_0F0F;
  endfunction

  // Fake cache: read word is registered on read_en_cache.
  always @(posedge clk) begin
    if (read_en_cache) data_out <= word_of({tag, index, blk_offset});
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_counters();
    check("hit_cnt", 64'(hit_cnt), 64'(hit_m));
    check("miss_cnt", 64'(miss_cnt), 64'(miss_m));
    check("wb_cnt", 64'(wb_cnt), 64'(wb_m));
  endtask

  // Driver + scoreboard for one complete CPU transaction.
  task automatic run_txn(input bit typ, input logic [30:0] addr, input logic [31:0] wd,
                         input bit is_hit, input bit dirty, input int ww, input int wa,
                         input bit remiss, input bit hold_busy);
    int c = 0, lat = -1, mreq = 0, mwe = 0, all4 = 0, wec = 0, rec = 0;
    int refills = 0, wcnt = 0, tgt;
    int exp_lat, exp_mreq;
    logic [31:0] rd = '0;
    logic [31:0] exp_q[$];

    exp_q.push_back(typ ? 32'h0 : word_of(addr));

    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = typ; cpu_addr = addr; cpu_wdata = wd;
    hit = is_hit; dirty_bit = dirty; mem_ack = 1'b0;
    #1 check("ready_idle", 64'(cpu_ready), 64'd1);
    @(posedge clk);

    while (lat < 0 && c < 300) begin
      @(negedge clk);
      c++;
      if (hold_busy) begin
        cpu_req_valid = 1'b1; cpu_req_type = 1'($urandom_range(0, 1));
        cpu_addr = 31'($urandom); cpu_wdata = $urandom;
      end else begin
        cpu_req_valid = 1'b0;
      end
      hit = is_hit || (refills > (remiss ? 1 : 0));
      dirty_bit = dirty && (refills == 0);
      if (mem_req) begin
        tgt = mem_we ? ww : wa;
        if (wcnt == tgt) begin mem_ack = 1'b1; wcnt = 0; end
        else begin mem_ack = 1'b0; wcnt++; end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (hold_busy) check("busy_not_ready", 64'(cpu_ready), 64'd0);
      if (mem_req) mreq++;
      if (mem_req && mem_we) mwe++;
      if (read_en_cache && write_en_cache && read_en_mem && write_en_mem) all4++;
      if (write_en_cache && !read_en_cache) wec++;
      if (read_en_cache && !write_en_cache) rec++;
      if (mem_req && !mem_we && mem_ack) refills++;
      if (cpu_resp_valid) begin
        lat = c;
        rd = cpu_rdata;
        check("resp_quiet", 64'({read_en_cache, write_en_cache, read_en_mem, write_en_mem, mem_req}), 64'd0);
        cpu_req_valid = 1'b0;
      end
    end

    if (lat < 0) check("resp_timeout", 64'd0, 64'd1);

    // transaction-level expectations
    exp_lat  = is_hit ? 2 : 4 + wa + (dirty ? 1 + ww : 0) + (remiss ? 2 + wa : 0);
    exp_mreq = is_hit ? 0 : (dirty ? ww + 1 : 0) + (wa + 1) * (remiss ? 2 : 1);
    if (is_hit) hit_m = sat(hit_m);
    else begin
      miss_m = sat(miss_m);
      if (dirty) wb_m = sat(wb_m);
    end

    check("latency", 64'(lat), 64'(exp_lat));
    check("rdata", 64'(rd), 64'(exp_q.pop_front()));
    check("mem_req_cycles", 64'(mreq), 64'(exp_mreq));
    check("mem_we_cycles", 64'(mwe), 64'((!is_hit && dirty) ? ww + 1 : 0));
    check("wb_strobe_cycles", 64'(all4), 64'((!is_hit && dirty) ? 1 : 0));
    check("wr_cache_cycles", 64'(wec), 64'((typ ? 1 : 0) + (is_hit ? 0 : (remiss ? 2 : 1))));
    check("rd_cache_cycles", 64'(rec), 64'(typ ? 0 : 1));
    check("fields", 64'({tag, index, blk_offset, req_type}), 64'({addr, typ}));
    check("data_in", 64'(data_in), 64'(wd));
    check_counters();

    @(negedge clk);
    mem_ack = 1'b0;
    #1 check("back_idle", 64'({cpu_ready, cpu_resp_valid, mem_req}), 64'b100);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    hit = 1'b0; dirty_bit = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(cpu_ready), 64'd1);
    check("rst_outputs", 64'({cpu_resp_valid, read_en_cache, write_en_cache, read_en_mem,
                              write_en_mem, mem_req, mem_we}), 64'd0);
    check("rst_fields", 64'({tag, index, blk_offset, req_type, data_in}), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;

    // directed scenarios
    run_txn(1'b0, 31'h10, 32'h0, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);         // cold clean miss
    run_txn(1'b0, 31'h10, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);         // repeat -> hit
    run_txn(1'b1, 31'h10, 32'hDEADBEEF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);  // write hit
    run_txn(1'b0, 31'h4010, 32'h0, 1'b0, 1'b1, 2, 1, 1'b0, 1'b0);       // dirty victim
    run_txn(1'b0, 31'h8010, 32'h0, 1'b0, 1'b0, 0, 2, 1'b0, 1'b1);       // busy hold
    run_txn(1'b1, 31'hC013, 32'h1234, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0);    // miss after refill

    // randomized traffic, long enough to saturate the counters
    for (int i = 0; i < 45; i++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      run_txn(1'($urandom_range(0, 1)), 31'($urandom), $urandom, h,
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
              !h && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0);
    end
    check("hit_saturated", 64'(hit_cnt), 64'(CMAX));

    // reset during the ALLOCATE wait
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 31'h20; hit = 1'b0;
    dirty_bit = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    #1 check("alloc_req", 64'({mem_req, mem_we}), 64'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    hit_m = 0; miss_m = 0; wb_m = 0;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mid_state", 64'(state_dbg), 64'd0);
    check("rst_mid_ready", 64'(cpu_ready), 64'd1);
    check_counters();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check("no_resp_after_rst", 64'({cpu_resp_valid, mem_req}), 64'd0);
    end

    run_txn(1'b0, 31'h20, 32'h0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
